out_writeback: RTL and testbench
================================

Name: out_writeback

Overview:
- Output write-back stage directly downstream of the activation block.
- Consumes activation row vectors (data + valid), buffers them in a small FIFO, generates BRAM A write addresses from the configured base (address_mat_c) and row stride, and drives the BRAM write port.
- Counts rows written and pulses a done signal.
- Replaces the single flop stage in the top level, so back-to-back rows survive BRAM port stalls.

Parameters:
- DWIDTH, 8, bits per element
- MAT_MUL_SIZE, 4, elements per row vector
- AWIDTH, 10, BRAM address width
- MASK_WIDTH, 4, byte-enable width (MAT_MUL_SIZE*DWIDTH/8)
- FIFO_DEPTH, 4, buffered rows (power of two, >=2)
- CNT_WIDTH, 8, row counter width

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- start_wb  in  1  one-cycle pulse; latch base/stride/num_rows, begin
- address_mat_c  in  AWIDTH  base address of first output row
- row_stride  in  AWIDTH  address increment per row (normally MAT_MUL_SIZE)
- num_rows  in  CNT_WIDTH  rows to write; 0 = complete immediately
- in_data  in  MAT_MUL_SIZE*DWIDTH  row from activation
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  FIFO can accept (not full)
- bram_grant  in  1  BRAM A port available for write this cycle
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  MAT_MUL_SIZE*DWIDTH  write data
- bram_we  out  MASK_WIDTH  byte write enables
- busy  out  1  high from start accepted until done
- done_wb  out  1  one-cycle pulse when last row written
- ovf  out  1  sticky overflow flag (only with OUT_WB_OVF_EN; tied 0 otherwise)

Behaviour:
- Reset (async, resetn=0): state IDLE; FIFO empty; counters 0; in_ready=0, bram_we=0, bram_addr=0, bram_wdata=0, busy=0, done_wb=0, ovf=0. Reset mid-operation discards all buffered rows; no partial write completes after resetn deasserts.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0; in_valid ignored. start_wb: latch base, stride, num_rows; clear write count and FIFO pointers. If num_rows==0 go DONE, else RUN.
- RUN:
  - in_ready = !full (registered flags).
  - Push when in_valid && in_ready.
  - Issue write when FIFO non-empty && bram_grant: next cycle bram_we = all ones, bram_addr = base + wr_count*stride (AWIDTH, wraps modulo 2^AWIDTH), bram_wdata = head row; pop; wr_count++.
  - Without an issued write, bram_we=0, bram_addr/wdata hold last value.
  - Push and pop in the same cycle are both allowed, including when full (pop frees space next cycle only; in_ready stays from registered full) and when empty (no bypass: the push is written no earlier than 1 cycle after).
  - Minimum latency from accepted in_valid to bram_we high: 2 cycles.
  - When the write of row num_rows-1 issues, go DONE.
  - Pushes beyond num_rows are dropped (in_ready=0 once accepted count == num_rows).
- DONE: done_wb=1 for exactly one cycle (aligned with the final bram_we cycle, or the cycle after start when num_rows==0), busy=0, return IDLE.
- busy=1 in RUN and in the cycle leading to DONE; start_wb while busy is ignored.
- bram_grant low stalls writes indefinitely; FIFO contents are preserved.

Optional Feature:
- OUT_WB_OVF_EN defined: in RUN, in_valid while FIFO full (in_ready=0) and accepted count < num_rows sets ovf sticky; cleared only by reset or start_wb. The row is dropped in both configurations.
- Undefined: no detection logic; ovf tied 0.

Test Plan:
- Basic: base=0x20, stride=4, num_rows=4, four back-to-back valid rows, grant=1 -> writes at 0x20,0x24,0x28,0x2C with matching data, we=4'hF, done_wb one cycle with last write, first write 2 cycles after first accept.
- Stall: grant=0 while 6 rows offered, num_rows=6 -> in_ready drops after 4 accepted; raise grant -> all 6 rows written in order, no loss.
- Wrap: base=0x3FC, stride=4, num_rows=2 -> addresses 0x3FC then 0x000.
- Zero rows: num_rows=0, start_wb -> done_wb next cycle, no bram_we, in_valid ignored.
- Reset mid-run: resetn low after 2 of 4 rows written -> all outputs 0 immediately; after release, no writes until new start_wb.
- OUT_WB_OVF_EN: grant=0, push 5 rows (num_rows=8) -> ovf=1 after the 5th valid, stays 1 until next start_wb; without macro ovf=0.

Source files
------------

// File: rtl/out_writeback.sv
// Output write-back stage: buffers activation rows in a small FIFO and writes them to BRAM A at base + n*stride.
// Optional sticky overflow detection is enabled by defining OUT_WB_OVF_EN.
module out_writeback #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int AWIDTH       = 10,
  parameter int MASK_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start_wb,
  input  logic [AWIDTH-1:0]              address_mat_c,
  input  logic [AWIDTH-1:0]              row_stride,
  input  logic [CNT_WIDTH-1:0]           num_rows,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           bram_grant,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]          bram_we,
  output logic                           busy,
  output logic                           done_wb,
  output logic                           ovf
);

  localparam int ROW_W  = MAT_MUL_SIZE * DWIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [ROW_W-1:0]     mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [FCNT_W-1:0]    fcnt_r, fcnt_s;
  logic [CNT_WIDTH-1:0] acc_r, acc_s;
  logic [CNT_WIDTH-1:0] num_rows_r, nrows_s;
  logic [CNT_WIDTH-1:0] wr_count_r;
  logic [AWIDTH-1:0]    stride_r;
  logic [AWIDTH-1:0]    addr_acc_r;
  logic                 in_ready_r, in_ready_s;
  logic [AWIDTH-1:0]    bram_addr_r;
  logic [ROW_W-1:0]     bram_wdata_r;
  logic [MASK_WIDTH-1:0] bram_we_r;
  logic                 busy_r, done_r;
  logic                 start_s, push_s, pop_s, last_s;

  // Next-state and per-cycle FIFO handshake decode
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_wb) begin
          start_s = 1'b1;
          state_s = (num_rows == CNT_WIDTH'(0)) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        push_s  = in_valid & in_ready_r;
        pop_s   = (fcnt_r != FCNT_W'(0)) & bram_grant;
        last_s  = pop_s & (wr_count_r == (num_rows_r - CNT_WIDTH'(1)));
        state_s = last_s ? DONE : RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next occupancy / accepted count; in_ready is registered from these
  always_comb begin
    fcnt_s     = fcnt_r;
    acc_s      = acc_r;
    nrows_s    = num_rows_r;
    in_ready_s = 1'b0;
    if (start_s) begin
      fcnt_s  = FCNT_W'(0);
      acc_s   = CNT_WIDTH'(0);
      nrows_s = num_rows;
    end else begin
      case ({push_s, pop_s})
        2'b10:   fcnt_s = fcnt_r + FCNT_W'(1);
        2'b01:   fcnt_s = fcnt_r - FCNT_W'(1);
        default: fcnt_s = fcnt_r;
      endcase
      acc_s = push_s ? (acc_r + CNT_WIDTH'(1)) : acc_r;
    end
    in_ready_s = (state_s == RUN) && (fcnt_s != FULL_CNT) && (acc_s != nrows_s);
  end

  // Row storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control state, pointers, address generation and the registered BRAM port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fcnt_r       <= '0;
      acc_r        <= '0;
      num_rows_r   <= '0;
      wr_count_r   <= '0;
      stride_r     <= '0;
      addr_acc_r   <= '0;
      in_ready_r   <= 1'b0;
      bram_addr_r  <= '0;
      bram_wdata_r <= '0;
      bram_we_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      fcnt_r     <= fcnt_s;
      acc_r      <= acc_s;
      num_rows_r <= nrows_s;
      in_ready_r <= in_ready_s;
      busy_r     <= (state_s == RUN);
      done_r     <= (state_s == DONE);
      if (start_s) begin
        stride_r   <= row_stride;
        addr_acc_r <= address_mat_c;
        wr_count_r <= '0;
        wr_ptr_r   <= '0;
        rd_ptr_r   <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
          wr_count_r <= wr_count_r + CNT_WIDTH'(1);
          addr_acc_r <= addr_acc_r + stride_r;
        end
      end
      // Address and data hold their last value when no write issues
      if (pop_s) begin
        bram_we_r    <= {MASK_WIDTH{1'b1}};
        bram_addr_r  <= addr_acc_r;
        bram_wdata_r <= mem_r[rd_ptr_r];
      end else begin
        bram_we_r    <= '0;
      end
    end
  end

`ifdef OUT_WB_OVF_EN
  logic ovf_r, ovf_set_s;

  assign ovf_set_s = (state_r == RUN) && in_valid && (fcnt_r == FULL_CNT) && (acc_r < num_rows_r);

  // Sticky overflow: a row offered while full and still expected is lost
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
    end else if (start_s) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready   = in_ready_r;
  assign bram_addr  = bram_addr_r;
  assign bram_wdata = bram_wdata_r;
  assign bram_we    = bram_we_r;
  assign busy       = busy_r;
  assign done_wb    = done_r;

endmodule

// File: tb/tb_out_writeback.sv
// Scoreboard bench for out_writeback: accepted rows queue their expected BRAM write, writes pop and compare.
module tb_out_writeback;

  localparam int AW = 10;
  localparam int CW = 8;
`ifdef OUT_WB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, start_wb, in_valid, in_ready, bram_grant, busy, done_wb, ovf;
  logic [AW-1:0] address_mat_c, row_stride, bram_addr;
  logic [CW-1:0] num_rows;
  logic [31:0]   in_data, bram_wdata;
  logic [3:0]    bram_we;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [AW-1:0] sb_base, sb_stride, ea;
  logic [31:0]   ed;
  int            sb_k;
  bit            acc;

  out_writeback dut (
    .clk(clk), .resetn(resetn), .start_wb(start_wb), .address_mat_c(address_mat_c),
    .row_stride(row_stride), .num_rows(num_rows), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bram_grant(bram_grant), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_we(bram_we), .busy(busy), .done_wb(done_wb), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] row(input int k);
    return 32'hA5000000 ^ (32'(k) * 32'h01030507);
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n);
    address_mat_c = b; row_stride = s; num_rows = n; start_wb = 1'b1;
    sb_base = b; sb_stride = s; sb_k = 0;
    exp_addr_q.delete(); exp_data_q.delete();
    @(negedge clk);
    start_wb = 1'b0;
    address_mat_c = ~b; row_stride = 10'd1; num_rows = 8'd99;
  endtask

  // Drive one cycle; an accepted row queues its expected write
  task automatic step(input bit v, input logic [31:0] d, input bit g);
    in_valid = v; in_data = d; bram_grant = g;
    acc = v && (in_ready === 1'b1);
    if (acc) begin
      exp_addr_q.push_back(AW'(sb_base + sb_k * sb_stride));
      exp_data_q.push_back(d);
      sb_k++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; start_wb = 1'b0; in_valid = 1'b0; in_data = 32'h0; bram_grant = 1'b0;
    address_mat_c = 10'h0; row_stride = 10'h0; num_rows = 8'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, bram_we, bram_addr, bram_wdata, busy, done_wb, ovf} !== 50'h0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b we=%h addr=%h data=%h busy=%b done=%b ovf=%b exp all 0",
               in_ready, bram_we, bram_addr, bram_wdata, busy, done_wb, ovf);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int ev = 0, nwr = 0, ndone = 0, t_acc = -1, t_wr = -1, cd;
    do_start(10'h020, 10'd4, 8'd4);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_run_entry got busy=%b rdy=%b exp 1 1", busy, in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      cd = cyc_cnt;
      step(ev < 4, row(ev), 1'b1);
      if (acc) begin
        if (t_acc < 0) t_acc = cd;
        ev++;
      end
      if (bram_we !== 4'h0) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++; $display("FAIL basic_wr unexpected addr=%h data=%h", bram_addr, bram_wdata);
        end else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (bram_we !== 4'hF || bram_addr !== ea || bram_wdata !== ed) begin
            failures++;
            $display("FAIL basic_wr got we=%h addr=%h data=%h exp we=f addr=%h data=%h", bram_we, bram_addr, bram_wdata, ea, ed);
          end
        end
        nwr++;
        if (t_wr < 0) t_wr = cyc_cnt;
      end
      if (done_wb === 1'b1) begin
        ndone++;
        checks++;
        if (nwr != 4 || bram_we !== 4'hF) begin
          failures++; $display("FAIL basic_done_align got writes=%0d we=%h exp 4 f", nwr, bram_we);
        end
      end
    end
    checks++;
    if (t_wr - t_acc != 2) begin
      failures++; $display("FAIL basic_latency got %0d exp 2", t_wr - t_acc);
    end
    checks++;
    if (nwr != 4 || ndone != 1 || busy !== 1'b0 || exp_addr_q.size() != 0) begin
      failures++; $display("FAIL basic_totals got writes=%0d dones=%0d busy=%b exp 4 1 0", nwr, ndone, busy);
    end
  endtask

  task automatic test_stall;
    int ev = 0, nwr = 0, ndone = 0, stall_wr = 0;
    do_start(10'h100, 10'd4, 8'd6);
    for (int c = 0; c < 8; c++) begin
      step(ev < 6, row(ev + 16), 1'b0);
      if (acc) ev++;
      if (bram_we !== 4'h0) stall_wr++;
    end
    checks++;
    if (ev != 4 || in_ready !== 1'b0 || stall_wr != 0) begin
      failures++; $display("FAIL stall_hold got accepted=%0d rdy=%b writes=%0d exp 4 0 0", ev, in_ready, stall_wr);
    end
    for (int c = 0; c < 20; c++) begin
      step(ev < 6, row(ev + 16), 1'b1);
      if (acc) ev++;
      if (bram_we !== 4'h0) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++; $display("FAIL stall_wr unexpected addr=%h data=%h", bram_addr, bram_wdata);
        end else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (bram_we !== 4'hF || bram_addr !== ea || bram_wdata !== ed) begin
            failures++;
            $display("FAIL stall_wr got we=%h addr=%h data=%h exp we=f addr=%h data=%h", bram_we, bram_addr, bram_wdata, ea, ed);
          end
        end
        nwr++;
      end
      if (done_wb === 1'b1) ndone++;
    end
    checks++;
    if (nwr != 6 || ev != 6 || ndone != 1 || exp_addr_q.size() != 0) begin
      failures++; $display("FAIL stall_totals got writes=%0d accepted=%0d dones=%0d exp 6 6 1", nwr, ev, ndone);
    end
  endtask

  task automatic test_wrap;
    int ev = 0, nwr = 0;
    logic [AW-1:0] obs [2];
    obs[0] = 10'h155; obs[1] = 10'h155;
    do_start(10'h3FC, 10'd4, 8'd2);
    for (int c = 0; c < 8; c++) begin
      step(ev < 2, row(ev + 32), 1'b1);
      if (acc) ev++;
      if (bram_we !== 4'h0) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++; $display("FAIL wrap_wr unexpected addr=%h", bram_addr);
        end else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (bram_addr !== ea || bram_wdata !== ed) begin
            failures++; $display("FAIL wrap_wr got addr=%h data=%h exp addr=%h data=%h", bram_addr, bram_wdata, ea, ed);
          end
        end
        if (nwr < 2) obs[nwr] = bram_addr;
        nwr++;
      end
    end
    checks++;
    if (nwr != 2 || obs[0] !== 10'h3FC || obs[1] !== 10'h000) begin
      failures++; $display("FAIL wrap_addrs got n=%0d %h %h exp 2 3fc 000", nwr, obs[0], obs[1]);
    end
  endtask

  task automatic test_zero;
    int bad = 0;
    in_valid = 1'b1; in_data = row(40); bram_grant = 1'b1;
    do_start(10'h080, 10'd4, 8'd0);
    checks++;
    if (done_wb !== 1'b1 || bram_we !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b we=%h busy=%b rdy=%b exp 1 0 0 0", done_wb, bram_we, busy, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b1, row(41 + c), 1'b1);
      if (done_wb !== 1'b0 || bram_we !== 4'h0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || exp_addr_q.size() != 0) begin
      failures++; $display("FAIL zero_quiet got bad_cycles=%0d queued=%0d exp 0 0", bad, exp_addr_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int ev = 0, nwr = 0, bad = 0;
    do_start(10'h040, 10'd4, 8'd4);
    for (int c = 0; c < 10 && nwr < 2; c++) begin
      step(ev < 4, row(ev + 48), 1'b1);
      if (acc) ev++;
      if (bram_we !== 4'h0) begin
        checks++;
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        if (bram_addr !== ea || bram_wdata !== ed) begin
          failures++; $display("FAIL rmid_wr got addr=%h data=%h exp addr=%h data=%h", bram_addr, bram_wdata, ea, ed);
        end
        nwr++;
      end
    end
    checks++;
    if (nwr != 2) begin
      failures++; $display("FAIL rmid_progress got writes=%0d exp 2", nwr);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({in_ready, bram_we, bram_addr, bram_wdata, busy, done_wb, ovf} !== 50'h0) begin
      failures++;
      $display("FAIL rmid_async got rdy=%b we=%h addr=%h data=%h busy=%b done=%b exp all 0",
               in_ready, bram_we, bram_addr, bram_wdata, busy, done_wb);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_addr_q.delete(); exp_data_q.delete();
    for (int c = 0; c < 6; c++) begin
      step(1'b1, row(60 + c), 1'b1);
      if (bram_we !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b0 || done_wb !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rmid_after_release got active_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_ovf;
    int ev = 0, nwr = 0, ndone = 0;
    do_start(10'h200, 10'd4, 8'd8);
    for (int c = 0; c < 6 && ev < 4; c++) begin
      step(1'b1, row(ev + 64), 1'b0);
      if (acc) ev++;
    end
    checks++;
    if (ev != 4 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL ovf_before got accepted=%0d ovf=%b rdy=%b exp 4 0 0", ev, ovf, in_ready);
    end
    step(1'b1, row(ev + 64), 1'b0);
    checks++;
    if (ovf !== OVF_EXP || acc) begin
      failures++; $display("FAIL ovf_set got ovf=%b accepted=%b exp %b 0", ovf, acc, OVF_EXP);
    end
    for (int c = 0; c < 24; c++) begin
      step(c >= 3 && ev < 8, row(ev + 64), c >= 3);
      if (acc) ev++;
      if (bram_we !== 4'h0) begin
        checks++;
        ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
        if (bram_addr !== ea || bram_wdata !== ed) begin
          failures++; $display("FAIL ovf_wr got addr=%h data=%h exp addr=%h data=%h", bram_addr, bram_wdata, ea, ed);
        end
        nwr++;
      end
      if (done_wb === 1'b1) ndone++;
    end
    checks++;
    if (nwr != 8 || ndone != 1 || ovf !== OVF_EXP) begin
      failures++; $display("FAIL ovf_sticky got writes=%0d dones=%0d ovf=%b exp 8 1 %b", nwr, ndone, ovf, OVF_EXP);
    end
    do_start(10'h000, 10'd4, 8'd0);
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got ovf=%b exp 0", ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_ovf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
